fm_dds_modulator: RTL and testbench
===================================

# fm_dds_modulator

Parametrised FM/DDS modulator, the successor to the single-mode FM modulator. It accepts audio samples over a valid/ready handshake and linearly interpolates between them. It adds a frequency deviation to the carrier increment and drives a phase accumulator into a pipelined piecewise-linear sine approximator, producing an offset-binary D-bit word for the 1-bit/R-2R DAC stage. Compared with its predecessor it adds run-time modes (FM / CW / mute), synchronous reset, sample interpolation, a fixed 3-stage pipeline and a carrier-wrap strobe.

## Interface
- A, 8: audio sample width, signed two's complement
- L, 12: deviation-increment width, unsigned
- N, 18: phase accumulator width
- M, 14: phase bits into sine approximator; R = M-2
- D, 5: output word width; D = R+1 is not required, and the top D-1 bits of the folded phase are used
- K, 2: interpolation shift; ramp length 2**K clocks; K = 0 disables interpolation (direct load)
- clk  in  1: sole clock, rising edge
- rst  in  1: synchronous, active-high reset
- mode  in  2: 0 = FM, 1 = CW (no deviation), 2 = mute, 3 = reserved (treated as mute)
- acc_inc  in  N: carrier phase increment
- df_inc  in  L: deviation increment at full-scale audio
- audio  in  A: signed sample
- audio_valid  in  1: sample present
- audio_ready  out  1: block can accept a sample
- rf  out  D: offset-binary modulated carrier
- phase_wrap  out  1: one-cycle strobe, aligned with rf, for the sample in which the accumulator overflowed

## Operation
- Handshake: a sample is accepted on a rising edge with audio_valid & audio_ready. audio_ready = 1 when no ramp is in progress.
- Interpolator: register x has signed A+K bits, with the integer part x[A+K-1:K]. On accept: step <= audio - x[A+K-1:K] (A+1 bits, signed), and the counter is loaded with 2**K. While the counter is nonzero, x += step each clock and the counter decrements. After 2**K clocks x equals audio·2**K exactly. audio_ready is low during the ramp. With K = 0, x <= audio on accept.
- Effective audio: a = x[A+K-1:K] in FM; a = 0 in CW and mute.
- mod_inc = (a · df_inc) >>> (A-1): arithmetic shift (floor), sign-extended or truncated to N bits.
- Stage 1: inc_r <= acc_inc + mod_inc (mod N).
- Stage 2: phase_acc <= phase_acc + inc_r (mod 2**N). Wrap is flagged when the unsigned carry-out = 1.
- Stage 3 (sine), with quadrant q = phase_acc[N-1:N-2] and p_r = phase_acc[N-3:N-2-R]:
  - Fold: pa = p_r for q ∈ {0,2}; pa = 2**R-1-p_r for q ∈ {1,3}. Negative iff q ∈ {2,3}.
  - Segment: s = pa[R-1:R-2]; p = pa[R-1:R-D+1]; Q = 2**(D-1)/4.
  - f = 2p if s = 0; f = Q + p if s ∈ {1,2}; f = 2**(D-1)-1 if s = 3.
  - rf_r <= 2**(D-1) + (neg ? -f : f), or 2**(D-1) in mute mode.
- In mute mode the phase accumulator keeps running, so the carrier is phase-continuous on unmute.
- Mode changes take effect at the stage they gate, with no flush.

## Timing
- Reset (sync, on rising edge with rst = 1): phase_acc = 0, inc_r = 0, x = 0, step = 0, counter = 0, rf = 2**(D-1), phase_wrap = 0, audio_ready = 1. Reset mid-ramp abandons the ramp, and audio_ready = 1 on the next cycle.
- Latency: acc_inc/df_inc/mode sampled at edge t affect inc_r at t, phase_acc at t+1, rf at t+2. Accepted audio affects x starting at the next edge.
- rf and phase_wrap are registered. No combinational path from inputs to outputs except audio_ready ← counter (registered).
- audio_valid while audio_ready = 0 is ignored; no buffering.
- Accumulator overflow wraps silently. Interpolator arithmetic cannot overflow: step is A+1 bits and x is A+K bits.

## Structure
- Package fm_pkg: mode constants (MODE_FM, MODE_CW, MODE_MUTE), the midscale helper 2**(D-1), and width-derivation constants (R = M-2).
- Sub-module fm_sine_approx: stage 3 (fold, segment, sign, output register, mute override), parametrised by R and D. The interpolator, increment stage and accumulator stay in the top level.

## Test plan
- Reset, then default params, mode = CW, acc_inc = 2**16, df_inc = 0 → rf repeats 16, 31, 16, 1. phase_wrap is high on the rf = 1→16 boundary every 4 cycles.
- FM, K = 0, df_inc = 256: audio 127 → inc_r = acc_inc + 254. audio -128 → acc_inc - 256. df_inc = 100, audio -1 → acc_inc - 1 (floor, not 0).
- K = 2, x = 0, accept audio 8 → x integer part 2, 4, 6, 8 over 4 clocks. audio_ready low 4 cycles. A valid presented mid-ramp is not accepted.
- Mute with acc_inc = 2**16 → rf = 16 constantly. Return to CW → rf resumes the phase sequence consistent with an uninterrupted accumulator.
- Assert rst mid-ramp and mid-carrier → next cycle rf = 16, audio_ready = 1, phase_wrap = 0, and the accumulator restarts from 0.
- Random audio/df_inc/acc_inc vs. a reference model, checking 3-cycle latency and bit-exact rf for 10k cycles.

Source files
------------

// File: rtl/fm_pkg.sv
// Shared definitions for the FM/DDS modulator: run-time modes and width helpers.
package fm_pkg;

  typedef enum logic [1:0] {
    MODE_FM   = 2'd0,
    MODE_CW   = 2'd1,
    MODE_MUTE = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  // Phase bits that reach the folded sine core: two quadrant bits are peeled off.
  function automatic int sine_bits(input int m);
    return m - 2;
  endfunction

  // Offset-binary zero level of a d-bit output word.
  function automatic int midscale(input int d);
    return 1 << (d - 1);
  endfunction

  // Mute and the reserved code both park the output at midscale.
  function automatic logic is_mute(input logic [1:0] mode);
    return mode[1];
  endfunction

endpackage

// File: rtl/fm_sine_approx.sv
// Sine stage: quadrant fold, three-segment piecewise-linear magnitude, sign and
// mute override, registered together with the delayed carrier-wrap flag.
module fm_sine_approx
  import fm_pkg::*;
#(
  parameter int R = 12,
  parameter int D = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mute,
  input  logic [1:0]         quad,
  input  logic [R-1:R-D+1]   p_hi,
  input  logic               wrap_in,
  output logic [D-1:0]       rf,
  output logic               phase_wrap
);

  localparam logic [D-1:0] MID  = D'(midscale(D));
  localparam logic [D-2:0] QTR  = (D-1)'(midscale(D) / 4);
  localparam logic [D-2:0] FMAX = (D-1)'(midscale(D) - 1);

  // Only the top D-1 bits of the folded phase matter, and 2**R-1-p_r is a
  // bitwise inversion, so folding just those bits is exact.
  logic [R-1:R-D+1] pa;
  logic [1:0]       seg;
  logic [D-2:0]     f;
  logic [D-1:0]     rf_d, rf_q;
  logic             wrap_d, wrap_q;

  // Fold, pick segment, apply sign and mute override.
  always_comb begin
    pa  = quad[0] ? ~p_hi : p_hi;
    seg = pa[R-1:R-2];
    if (seg == 2'd0) begin
      f = {pa[R-2:R-D+1], 1'b0};
    end else if (seg == 2'd3) begin
      f = FMAX;
    end else begin
      f = QTR + pa;
    end
    if (mute) begin
      rf_d = MID;
    end else if (quad[1]) begin
      rf_d = MID - {1'b0, f};
    end else begin
      rf_d = MID + {1'b0, f};
    end
    wrap_d = wrap_in;
  end

  // Output register; wrap is delayed here so it lines up with rf.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_q   <= MID;
      wrap_q <= 1'b0;
    end else begin
      rf_q   <= rf_d;
      wrap_q <= wrap_d;
    end
  end

  assign rf         = rf_q;
  assign phase_wrap = wrap_q;

endmodule

// File: rtl/fm_dds_modulator.sv
// FM/DDS modulator top: audio handshake and linear interpolator, deviation
// scaling, increment register, phase accumulator, and the sine output stage.
module fm_dds_modulator
  import fm_pkg::*;
#(
  parameter int A = 8,
  parameter int L = 12,
  parameter int N = 18,
  parameter int M = 14,
  parameter int D = 5,
  parameter int K = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic [N-1:0]        acc_inc,
  input  logic [L-1:0]        df_inc,
  input  logic signed [A-1:0] audio,
  input  logic                audio_valid,
  output logic                audio_ready,
  output logic [D-1:0]        rf,
  output logic                phase_wrap
);

  localparam int R  = sine_bits(M);
  localparam int XW = A + K;
  localparam int CW = K + 1;
  localparam int P  = A + L + 1;

  logic signed [XW-1:0] x_q, x_d;
  logic signed [A:0]    step_q, step_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 accept;
  logic signed [A-1:0]  x_int;

  logic signed [A-1:0]  a_eff;
  logic signed [P-1:0]  prod;
  logic signed [N-1:0]  mod_inc;
  logic [N-1:0]         inc_q, inc_d;
  logic [N:0]           phase_sum;
  logic [N-1:0]         phase_q, phase_d;
  logic                 wrap_q, wrap_d;

  assign x_int       = x_q[XW-1:K];
  assign audio_ready = (cnt_q == '0);
  assign accept      = audio_valid & audio_ready;

  // Interpolator: load a ramp on accept, then step x toward the new sample.
  always_comb begin
    x_d    = x_q;
    step_d = step_q;
    cnt_d  = cnt_q;
    if (K == 0) begin
      if (accept) begin
        x_d = XW'(audio);
      end
    end else if (cnt_q != '0) begin
      x_d   = x_q + XW'(step_q);
      cnt_d = cnt_q - CW'(1);
    end else if (accept) begin
      step_d = (A+1)'(audio) - (A+1)'(x_int);
      cnt_d  = CW'(2 ** K);
    end
  end

  // Deviation scaling, increment stage and accumulator next-state.
  always_comb begin
    a_eff     = (mode == MODE_FM) ? x_int : '0;
    prod      = P'(a_eff) * P'($signed({1'b0, df_inc}));
    mod_inc   = N'(prod >>> (A - 1));
    inc_d     = acc_inc + $unsigned(mod_inc);
    phase_sum = {1'b0, phase_q} + {1'b0, inc_q};
    phase_d   = phase_sum[N-1:0];
    wrap_d    = phase_sum[N];
  end

  // Interpolator, increment and accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      inc_q   <= '0;
      phase_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      x_q     <= x_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      inc_q   <= inc_d;
      phase_q <= phase_d;
      wrap_q  <= wrap_d;
    end
  end

  fm_sine_approx #(
    .R (R),
    .D (D)
  ) u_sine (
    .clk        (clk),
    .rst        (rst),
    .mute       (is_mute(mode)),
    .quad       (phase_q[N-1:N-2]),
    .p_hi       (phase_q[N-3 -: D-1]),
    .wrap_in    (wrap_q),
    .rf         (rf),
    .phase_wrap (phase_wrap)
  );

endmodule

// File: tb/tb_fm_dds_modulator.sv
// Testbench for fm_dds_modulator: directed scenarios plus randomized traffic,
// checked cycle by cycle against an arithmetic reference model.
module tb_fm_dds_modulator;

  localparam int A = 8;
  localparam int L = 12;
  localparam int N = 18;
  localparam int M = 14;
  localparam int D = 5;
  localparam int K = 2;
  localparam int R = M - 2;
  localparam int MID = 1 << (D - 1);
  localparam longint PMOD = longint'(1) << N;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          mode;
  logic [N-1:0]        acc_inc;
  logic [L-1:0]        df_inc;
  logic signed [A-1:0] audio;
  logic                audio_valid;
  logic                audio_ready;
  logic [D-1:0]        rf;
  logic                phase_wrap;

  always #5 clk = ~clk;

  fm_dds_modulator #(
    .A (A), .L (L), .N (N), .M (M), .D (D), .K (K)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .acc_inc     (acc_inc),
    .df_inc      (df_inc),
    .audio       (audio),
    .audio_valid (audio_valid),
    .audio_ready (audio_ready),
    .rf          (rf),
    .phase_wrap  (phase_wrap)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: values as they should appear after the last edge.
  longint m_inc, m_phase, m_x4;
  bit     m_w, m_wo;
  int     m_rf;
  longint m_ramp[$];

  int cw_pat[4] = '{31, 16, 1, 16};

  function automatic longint fdiv(input longint n, input longint d);
    longint q;
    q = n / d;
    if ((n % d != 0) && (n < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int sine_ref(input longint ph);
    longint q, pr, pa, s, p, f;
    q  = ph / (PMOD / 4);
    pr = (ph / (longint'(1) << (N - 2 - R))) % (longint'(1) << R);
    pa = (q == 1 || q == 3) ? ((longint'(1) << R) - 1 - pr) : pr;
    s  = pa / (longint'(1) << (R - 2));
    p  = pa / (longint'(1) << (R - D + 1));
    if (s == 0)      f = 2 * p;
    else if (s == 3) f = MID - 1;
    else             f = MID / 4 + p;
    return int'((q >= 2) ? MID - f : MID + f);
  endfunction

  task automatic model_reset();
    m_inc = 0; m_phase = 0; m_x4 = 0;
    m_w = 1'b0; m_wo = 1'b0; m_rf = MID;
    m_ramp.delete();
  endtask

  task automatic model_edge();
    longint a, mi, ni, sum, prev, aud, acc, df;
    aud = longint'(audio);
    acc = longint'(acc_inc);
    df  = longint'(df_inc);
    a   = (mode == 2'd0) ? fdiv(m_x4, longint'(1) << K) : 0;
    mi  = fdiv(a * df, longint'(1) << (A - 1));
    ni  = (acc + mi) % PMOD;
    if (ni < 0) ni = ni + PMOD;
    sum  = m_phase + m_inc;
    m_rf = (mode >= 2'd2) ? MID : sine_ref(m_phase);
    m_wo = m_w;
    m_w  = (sum >= PMOD);
    m_phase = sum % PMOD;
    m_inc   = ni;
    if (m_ramp.size() != 0) begin
      m_x4 = m_ramp.pop_front();
    end else if (audio_valid) begin
      prev = fdiv(m_x4, longint'(1) << K);
      for (int i = 1; i <= (1 << K); i++)
        m_ramp.push_back(prev * (longint'(1) << K) + (aud - prev) * i);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock, keeping the model in step, and compare all outputs.
  task automatic tick();
    if (rst) model_reset();
    else model_edge();
    @(posedge clk);
    #1;
    chk("rf", 32'(rf), 32'(m_rf));
    chk("phase_wrap", 32'(phase_wrap), 32'(m_wo));
    chk("audio_ready", 32'(audio_ready), 32'(m_ramp.size() == 0));
  endtask

  initial begin
    rst = 1'b1; mode = 2'd1; acc_inc = '0; df_inc = '0; audio = '0; audio_valid = 1'b0;
    tick();
    chk("reset_rf", 32'(rf), 32'(MID));
    chk("reset_ready", 32'(audio_ready), 32'd1);
    chk("reset_wrap", 32'(phase_wrap), 32'd0);

    // CW carrier at a quarter-turn per clock.
    rst = 1'b0; acc_inc = N'(1 << 16);
    tick(); tick();
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("cw_rf", 32'(rf), 32'(cw_pat[i % 4]));
      chk("cw_wrap", 32'(phase_wrap), 32'(i % 4 == 3));
    end

    // Mute holds midscale while the accumulator keeps running.
    mode = 2'd2;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("mute_rf", 32'(rf), 32'(MID));
    end
    mode = 2'd3;
    tick();
    chk("rsvd_rf", 32'(rf), 32'(MID));
    mode = 2'd1;
    for (int i = 0; i < 8; i++) tick();

    // FM increments at full-scale positive/negative and the floor case.
    rst = 1'b1; tick(); rst = 1'b0;
    mode = 2'd0; df_inc = 12'd256; acc_inc = N'((1 << 16) - 254);
    audio = 8'sd127; audio_valid = 1'b1; tick(); audio_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    acc_inc = N'((1 << 16) + 256);
    audio = -8'sd128; audio_valid = 1'b1; tick(); audio_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    df_inc = 12'd100; acc_inc = N'(1);
    audio = -8'sd1; audio_valid = 1'b1; tick(); audio_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("floor_rf_hold", 32'(rf), 32'(MID));

    // Ramp: ready low four cycles, mid-ramp valid ignored.
    rst = 1'b1; tick(); rst = 1'b0;
    mode = 2'd0; acc_inc = '0; df_inc = 12'd128;
    audio = 8'sd8; audio_valid = 1'b1;
    tick(); chk("ramp_ready0", 32'(audio_ready), 32'd0);
    audio = 8'sd50;
    tick(); chk("ramp_ready1", 32'(audio_ready), 32'd0);
    tick(); chk("ramp_ready2", 32'(audio_ready), 32'd0);
    audio_valid = 1'b0;
    tick(); chk("ramp_ready3", 32'(audio_ready), 32'd0);
    tick(); chk("ramp_done", 32'(audio_ready), 32'd1);
    for (int i = 0; i < 6; i++) tick();

    // Reset in the middle of a ramp with the carrier running.
    mode = 2'd0; acc_inc = N'(12345); df_inc = 12'd900;
    audio = -8'sd100; audio_valid = 1'b1; tick(); audio_valid = 1'b0;
    tick();
    rst = 1'b1; tick();
    chk("rst_mid_rf", 32'(rf), 32'(MID));
    chk("rst_mid_ready", 32'(audio_ready), 32'd1);
    chk("rst_mid_wrap", 32'(phase_wrap), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    // Randomized traffic.
    for (int i = 0; i < 10000; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      mode = (r < 6) ? 2'd0 : (r < 8) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      acc_inc = N'($urandom);
      df_inc = L'($urandom);
      audio = A'($urandom);
      audio_valid = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 999) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
